// File: rtl/lcd_cmd_queue.sv
// Command/character queue feeding an LCD controller: circular buffer plus an issue FSM
// that hands one entry at a time to the controller. Optional macro: LCD_QUEUE_OVF_EN.
`timescale 1ns/1ps
module lcd_cmd_queue #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 8,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_en,
    input  logic                    in_cmd,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    init_done,
    input  logic                    busy,
    output logic                    out_en,
    output logic                    out_cmd,
    output logic [DATA_W-1:0]       out_data,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef LCD_QUEUE_OVF_EN
    ,
    output logic                    ovf,
    output logic [7:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                full_q, almost_full_q, empty_q;
    logic                out_en_q, out_cmd_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W:0]     mem_q [DEPTH];
    logic                pop, push;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && init_done && !busy) begin
                    pop     = 1'b1;
                    state_d = WAIT_ACK;
                    timer_d = '0;
                end
            end
            WAIT_ACK: begin
                // Give up on an acknowledge that never comes so the queue cannot stall.
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = in_en && (!full_q || pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            empty_q       <= 1'b1;
            out_en_q      <= 1'b0;
            out_cmd_q     <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == CW'(DEPTH));
            almost_full_q <= (count_d >= CW'(AF_LEVEL));
            empty_q       <= (count_d == '0);
            out_en_q      <= pop;
            if (pop) begin
                {out_cmd_q, out_data_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_cmd, in_data};
        end
    end

`ifdef LCD_QUEUE_OVF_EN
    logic       ovf_q;
    logic [7:0] drop_cnt_q;
    logic       reject;

    assign reject = in_en && !push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (reject) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;
`endif

    assign out_en      = out_en_q;
    assign out_cmd     = out_cmd_q;
    assign out_data    = out_data_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign empty       = empty_q;
    assign count       = count_q;

endmodule
